mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port XM_memRead, input, 1: load request from execute/memory register.
REQ-004 SHALL have port XM_memWrite, input, 1: store request from execute/memory register.
REQ-005 SHALL have port XM_aluOut, input, 16: memory address / ALU result.
REQ-006 SHALL have port XM_writeData, input, 16: store data.
REQ-007 SHALL have port XM_regSrc, input, 2: writeback source select, passed through.
REQ-008 SHALL have port XM_next_pc, input, 16: next PC, passed through.
REQ-009 SHALL have ports mem_req (output, 1), mem_wr (output, 1), mem_addr (output, 16), mem_wdata (output, 16): multi-cycle data memory request.
REQ-010 SHALL have ports mem_rdata (input, 16) and mem_done (input, 1): memory completion; mem_rdata valid only with mem_done.
REQ-011 SHALL have port stall, output, 1: freezes fetch through execute/memory registers while high.
REQ-012 SHALL have ports MW_readData, MW_aluOut, MW_next_pc (output, 16 each), MW_regSrc (output, 2), MW_valid (output, 1): memory/writeback register outputs.
REQ-013 SHALL have port err, output, 1: sticky access error flag.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE, no access: stall=0; MW register loads XM values with MW_readData=0 and MW_valid=1 each cycle.
REQ-016 IDLE, access (read or write) with XM_aluOut[0]=0: mem_req=1 for exactly that cycle, mem_addr=XM_aluOut, mem_wdata=XM_writeData, mem_wr=XM_memWrite; stall=1; next state BUSY.
REQ-017 Read and write both high: treated as write; err set.
REQ-018 Access with XM_aluOut[0]=1 (unaligned): no mem_req; err set; handled as no-access cycle with MW_valid=0.
REQ-019 BUSY: mem_req=0, stall=1, MW register holds; on mem_done, capture mem_rdata (reads) or 0 (writes) into a data holding register; next state DONE.
REQ-020 mem_done in the same cycle as mem_req (zero-wait memory): capture immediately and go directly to DONE.
REQ-021 DONE: stall=0; MW register loads XM values plus captured data, MW_valid=1; next state IDLE; mem_req=0 even if a new access is present (back-to-back access starts in the following cycle).
REQ-022 mem_done in IDLE or DONE SHALL be ignored.
REQ-023 Access latency: minimum 2 cycles (request + DONE); stall high for exactly the cycles spent in request and BUSY.
REQ-024 err SHALL remain set until reset.

Reset
REQ-025 rst SHALL force state IDLE and clear all MW outputs, data holding register, err, stall, mem_req, mem_wr, mem_addr, mem_wdata to 0, taking priority over mem_done.
REQ-026 Reset during BUSY SHALL abandon the outstanding access; a later mem_done is ignored.

Configuration
REQ-027 Macro MEM_TIMEOUT_EN defined: 4-bit watchdog counts BUSY cycles; at count 15 without mem_done, set err, MW_valid=0 for that instruction, go to DONE.
REQ-028 Macro MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely.

Structure
REQ-029 State encoding, timeout limit (15) and regSrc encodings SHALL live in shared package cpu_pkg.
REQ-030 The MW register SHALL be a sub-module mw_pipe (enable-gated bank of dff), instantiated once.

Verification
REQ-031 Read 0x0040, mem_done after 3 BUSY cycles with rdata 0xBEEF -> stall high 4 cycles, MW_readData=0xBEEF, MW_valid=1 in following cycle.
REQ-032 Write 0x1234 to 0x0010 with same-cycle mem_done -> one mem_req, mem_wr=1, stall high 1 cycle, MW_readData=0.
REQ-033 Read at 0x0011 -> no mem_req, err=1, MW_valid=0.
REQ-034 Two consecutive loads -> second mem_req exactly one cycle after first DONE; data in order.
REQ-035 rst asserted in BUSY, then mem_done -> all outputs 0, state IDLE, capture ignored.
REQ-036 With MEM_TIMEOUT_EN, no mem_done -> after 15 BUSY cycles err=1, stall falls, MW_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-stage FSM encoding, watchdog limit, writeback source codes.
// Pure declarations, no logic; latency and backpressure are not applicable.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // BUSY cycles allowed before an outstanding access is declared lost
  localparam logic [3:0] MEM_TMO_LIMIT = 4'd15;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_MEM = 2'd1,
    RS_PC  = 2'd2,
    RS_IMM = 2'd3
  } regsrc_e;

  typedef struct packed {
    logic [15:0] read_data;
    logic [15:0] alu_out;
    logic [15:0] next_pc;
    logic [1:0]  reg_src;
    logic        valid;
  } mw_t;

  function automatic mw_t mk_mw(input logic [15:0] read_data,
                                input logic [15:0] alu_out,
                                input logic [15:0] next_pc,
                                input logic [1:0]  reg_src,
                                input logic        valid);
    mw_t r;
    r.read_data = read_data;
    r.alu_out   = alu_out;
    r.next_pc   = next_pc;
    r.reg_src   = reg_src;
    r.valid     = valid;
    return r;
  endfunction

endpackage

// File: rtl/mw_pipe.sv
// Memory/writeback pipeline register: enable-gated bank of flops, one cycle latency.
// Holds its contents while en_i is low, which is how the stage absorbs memory stalls.
module mw_pipe
  import cpu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  mw_t  d_i,
  output mw_t  q_o
);

  mw_t mw_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mw_q <= '0;
    end else if (en_i) begin
      mw_q <= d_i;
    end
  end

  assign q_o = mw_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: multi-cycle data memory handshake, min 2-cycle access, stall upstream while waiting.
// Optional BUSY watchdog enabled by defining MEM_TIMEOUT_EN; otherwise BUSY waits for mem_done indefinitely.
module mem_stage_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        XM_memRead,
  input  logic        XM_memWrite,
  input  logic [15:0] XM_aluOut,
  input  logic [15:0] XM_writeData,
  input  logic [1:0]  XM_regSrc,
  input  logic [15:0] XM_next_pc,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall,
  output logic [15:0] MW_readData,
  output logic [15:0] MW_aluOut,
  output logic [15:0] MW_next_pc,
  output logic [1:0]  MW_regSrc,
  output logic        MW_valid,
  output logic        err
);

  mem_state_e  state_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] data_q;
  logic        wr_q;
  logic        tmo_q;
  logic        err_q;
`ifdef MEM_TIMEOUT_EN
  logic [3:0]  cnt_q;
`endif

  logic access;
  logic unaligned;
  logic issue;
  logic mw_en_d;
  mw_t  mw_d;
  mw_t  mw_q;

  assign access    = XM_memRead | XM_memWrite;
  assign unaligned = XM_aluOut[0];
  assign issue     = (state_q == ST_IDLE) && access && !unaligned;

  // Request-cycle outputs must follow XM combinationally so a zero-wait memory can answer in the same cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    stall     = 1'b0;
    mw_en_d   = 1'b0;
    mw_d      = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            mem_req   = 1'b1;
            mem_wr    = XM_memWrite;
            mem_addr  = XM_aluOut;
            mem_wdata = XM_writeData;
            stall     = 1'b1;
          end else begin
            mw_en_d = 1'b1;
            mw_d    = mk_mw(16'h0000, XM_aluOut, XM_next_pc, XM_regSrc,
                            !(access && unaligned));
          end
        end
        ST_BUSY: begin
          stall     = 1'b1;
          mem_wr    = wr_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        ST_DONE: begin
          mw_en_d = 1'b1;
          mw_d    = mk_mw(data_q, XM_aluOut, XM_next_pc, XM_regSrc, !tmo_q);
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      data_q  <= 16'h0000;
      wr_q    <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            if (unaligned) begin
              err_q <= 1'b1;
            end else begin
              // Read+write together resolves as a write but is still flagged.
              if (XM_memRead && XM_memWrite) begin
                err_q <= 1'b1;
              end
              wr_q    <= XM_memWrite;
              addr_q  <= XM_aluOut;
              wdata_q <= XM_writeData;
              tmo_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
              cnt_q   <= 4'd0;
`endif
              if (mem_done) begin
                data_q  <= XM_memWrite ? 16'h0000 : mem_rdata;
                state_q <= ST_DONE;
              end else begin
                state_q <= ST_BUSY;
              end
            end
          end
        end
        ST_BUSY: begin
          if (mem_done) begin
            data_q  <= wr_q ? 16'h0000 : mem_rdata;
            state_q <= ST_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q + 4'd1 == MEM_TMO_LIMIT) begin
            err_q   <= 1'b1;
            tmo_q   <= 1'b1;
            data_q  <= 16'h0000;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
`endif
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  mw_pipe u_mw_pipe (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (mw_en_d),
    .d_i   (mw_d),
    .q_o   (mw_q)
  );

  assign MW_readData = mw_q.read_data;
  assign MW_aluOut   = mw_q.alu_out;
  assign MW_next_pc  = mw_q.next_pc;
  assign MW_regSrc   = mw_q.reg_src;
  assign MW_valid    = mw_q.valid;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed instructions feed scoreboards for memory requests and MW register loads.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        XM_memRead, XM_memWrite;
  logic [15:0] XM_aluOut, XM_writeData, XM_next_pc;
  logic [1:0]  XM_regSrc;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done;
  logic        stall;
  logic [15:0] MW_readData, MW_aluOut, MW_next_pc;
  logic [1:0]  MW_regSrc;
  logic        MW_valid;
  logic        err;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .XM_memRead   (XM_memRead),
    .XM_memWrite  (XM_memWrite),
    .XM_aluOut    (XM_aluOut),
    .XM_writeData (XM_writeData),
    .XM_regSrc    (XM_regSrc),
    .XM_next_pc   (XM_next_pc),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .stall        (stall),
    .MW_readData  (MW_readData),
    .MW_aluOut    (MW_aluOut),
    .MW_next_pc   (MW_next_pc),
    .MW_regSrc    (MW_regSrc),
    .MW_valid     (MW_valid),
    .err          (err)
  );

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  logic [50:0] exp_mw_q[$];
  logic [32:0] exp_req_q[$];

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MW monitor: a cycle with stall low outside reset loads the MW register at the next edge.
  initial begin : mw_mon
    logic fire;
    forever begin
      @(negedge clk);
      fire = !rst && !stall;
      @(posedge clk);
      #1;
      if (fire) begin
        if (exp_mw_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mw_unexpected: got load %0h with no expected entry",
                   {MW_readData, MW_aluOut, MW_next_pc, MW_regSrc, MW_valid});
        end else begin
          chk("mw_load", {13'h0, MW_readData, MW_aluOut, MW_next_pc, MW_regSrc, MW_valid},
              {13'h0, exp_mw_q.pop_front()});
        end
      end
    end
  end

  initial begin : req_mon
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (exp_req_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL req_unexpected: got %0h with no expected entry", {mem_wr, mem_addr, mem_wdata});
        end else begin
          chk("mem_req", {31'h0, mem_wr, mem_addr, mem_wdata}, {31'h0, exp_req_q.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // One instruction held in XM until the stage releases it; delay = cycle index (0 = request cycle) of mem_done.
  task automatic run_instr(input string name, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wd,
                           input logic [1:0] rs, input logic [15:0] npc,
                           input int delay, input logic [15:0] rdata, input logic force_done,
                           input logic [15:0] exp_data, input logic exp_valid,
                           output int stall_n, output int req_n,
                           output int done_cyc, output int req_cyc);
    bit fin;
    bit acc_ok;
    fin    = 1'b0;
    acc_ok = (rd || wr) && !addr[0];
    XM_memRead   = rd;
    XM_memWrite  = wr;
    XM_aluOut    = addr;
    XM_writeData = wd;
    XM_regSrc    = rs;
    XM_next_pc   = npc;
    exp_mw_q.push_back({exp_data, addr, npc, rs, exp_valid});
    if (acc_ok) exp_req_q.push_back({wr, addr, wd});
    stall_n  = 0;
    req_n    = 0;
    done_cyc = -1;
    req_cyc  = -1;
    for (int c = 0; c < 64 && !fin; c++) begin
      mem_done  = force_done || (acc_ok && c == delay);
      mem_rdata = mem_done ? rdata : 16'h5A5A;
      @(negedge clk);
      if (mem_req) begin
        req_n++;
        req_cyc = cyc_cnt;
      end
      if (stall) stall_n++;
      else begin
        fin      = 1'b1;
        done_cyc = cyc_cnt;
      end
      @(posedge clk);
      #2;
      mem_done = 1'b0;
    end
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL %s_release: got stall still high after 64 cycles expected release", name);
    end
  endtask

  int s, r, d, q, d1;

  initial begin : stim
    rst = 1'b1;
    XM_memRead = 1'b1; XM_memWrite = 1'b0; XM_aluOut = 16'h0040;
    XM_writeData = 16'h0; XM_regSrc = 2'd0; XM_next_pc = 16'h0;
    mem_done = 1'b1; mem_rdata = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset must dominate both a pending access and mem_done.
    chk("rst_ctrl", {28'h0, stall, mem_req, mem_wr, mem_addr, mem_wdata, err}, 64'h0);
    chk("rst_mw", {13'h0, MW_readData, MW_aluOut, MW_next_pc, MW_regSrc, MW_valid}, 64'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    mem_done = 1'b0;

    run_instr("rd_0040", 1, 0, 16'h0040, 16'h0000, 2'd1, 16'h0104, 3, 16'hBEEF, 0,
              16'hBEEF, 1, s, r, d, q);
    chk("rd_0040_stall", s, 4);
    chk("rd_0040_req", r, 1);

    run_instr("wr_0010", 0, 1, 16'h0010, 16'h1234, 2'd0, 16'h0108, 0, 16'hFFFF, 0,
              16'h0000, 1, s, r, d, q);
    chk("wr_0010_stall", s, 1);
    chk("wr_0010_req", r, 1);
    chk("err_clean", err, 0);

    run_instr("ld_a", 1, 0, 16'h0020, 16'h0000, 2'd1, 16'h010C, 1, 16'h1111, 0,
              16'h1111, 1, s, r, d1, q);
    chk("ld_a_stall", s, 2);
    run_instr("ld_b", 1, 0, 16'h0022, 16'h0000, 2'd1, 16'h0110, 2, 16'h2222, 0,
              16'h2222, 1, s, r, d, q);
    chk("ld_b_stall", s, 3);
    chk("ld_b_req_after_done", q, d1 + 1);

    run_instr("idle_done", 0, 0, 16'h0055, 16'h0000, 2'd0, 16'h0114, -1, 16'h7777, 1,
              16'h0000, 1, s, r, d, q);
    chk("idle_done_stall", s, 0);
    chk("idle_done_req", r, 0);
    chk("idle_done_err", err, 0);

    run_instr("rdwr", 1, 1, 16'h0030, 16'h00AB, 2'd0, 16'h0118, 1, 16'h3333, 0,
              16'h0000, 1, s, r, d, q);
    chk("rdwr_stall", s, 2);
    chk("rdwr_err", err, 1);

    // Reset while BUSY, then a stale mem_done.
    XM_memRead = 1'b1; XM_memWrite = 1'b0; XM_aluOut = 16'h0080;
    XM_writeData = 16'h0000; XM_regSrc = 2'd1; XM_next_pc = 16'h0120;
    exp_req_q.push_back({1'b0, 16'h0080, 16'h0000});
    @(negedge clk);
    chk("rstbusy_req_stall", stall, 1);
    @(posedge clk); #2;
    @(negedge clk);
    chk("rstbusy_busy_stall", stall, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("rstbusy_ctrl", {28'h0, stall, mem_req, mem_wr, mem_addr, mem_wdata}, 64'h0);
    @(posedge clk); #2;
    chk("rstbusy_mw_err", {12'h0, MW_readData, MW_aluOut, MW_next_pc, MW_regSrc, MW_valid, err}, 64'h0);
    rst = 1'b0;
    run_instr("post_rst", 0, 0, 16'h0000, 16'h0000, 2'd0, 16'h0000, -1, 16'hCCCC, 1,
              16'h0000, 1, s, r, d, q);
    chk("post_rst_stall", s, 0);
    chk("post_rst_req", r, 0);
    chk("post_rst_err", err, 0);

    run_instr("unaligned", 1, 0, 16'h0011, 16'h0000, 2'd1, 16'h0124, 0, 16'h9999, 0,
              16'h0000, 0, s, r, d, q);
    chk("unaligned_stall", s, 0);
    chk("unaligned_req", r, 0);
    chk("unaligned_err", err, 1);

    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
`ifdef MEM_TIMEOUT_EN
    run_instr("timeout", 1, 0, 16'h0044, 16'h0000, 2'd1, 16'h0128, -1, 16'h4444, 0,
              16'h0000, 0, s, r, d, q);
    chk("timeout_stall", s, 16);
    chk("timeout_err", err, 1);
`else
    run_instr("long_wait", 1, 0, 16'h0044, 16'h0000, 2'd1, 16'h0128, 30, 16'h4444, 0,
              16'h4444, 1, s, r, d, q);
    chk("long_wait_stall", s, 31);
    chk("long_wait_err", err, 0);
`endif

    chk("mw_queue_drained", exp_mw_q.size(), 0);
    chk("req_queue_drained", exp_req_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
